// File: rtl/conv2d_seq_ctrl_if.sv
// Buffer/sink bus of the conv2d sequencer: input, weight and bias RAM read
// ports (1-cycle latency) plus the valid/ready result write port.
//   master (sequencer): drives in_addr, w_addr, b_addr, out_valid, out_addr, out_data;
//                       samples in_data, w_data, b_data, out_ready
//   slave  (buffers)  : the mirror image
interface conv2d_seq_ctrl_if #(
    parameter int unsigned in_channels  = 1,
    parameter int unsigned out_channels = 1,
    parameter int unsigned kernel_rows  = 3,
    parameter int unsigned kernel_cols  = 3,
    parameter int unsigned stride_row   = 1,
    parameter int unsigned stride_col   = 1,
    parameter int unsigned rows         = 28,
    parameter int unsigned cols         = 28,
    parameter int unsigned data_size    = 8
);
    // Address width that never collapses to zero bits for single-entry spaces.
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned out_rows = (rows >= kernel_rows && stride_row > 0)
                                     ? (rows - kernel_rows) / stride_row + 1 : 1;
    localparam int unsigned out_cols = (cols >= kernel_cols && stride_col > 0)
                                     ? (cols - kernel_cols) / stride_col + 1 : 1;
    localparam int unsigned in_aw    = cw(in_channels * rows * cols);
    localparam int unsigned w_aw     = cw(out_channels * in_channels * kernel_rows * kernel_cols);
    localparam int unsigned b_aw     = cw(out_channels);
    localparam int unsigned o_aw     = cw(out_channels * out_rows * out_cols);

    logic [in_aw-1:0]     in_addr;
    logic [data_size-1:0] in_data;
    logic [w_aw-1:0]      w_addr;
    logic [data_size-1:0] w_data;
    logic [b_aw-1:0]      b_addr;
    logic [data_size-1:0] b_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [o_aw-1:0]      out_addr;
    logic [data_size-1:0] out_data;

    modport master (
        output in_addr, w_addr, b_addr, out_valid, out_addr, out_data,
        input  in_data, w_data, b_data, out_ready
    );

    modport slave (
        input  in_addr, w_addr, b_addr, out_valid, out_addr, out_data,
        output in_data, w_data, b_data, out_ready
    );
endinterface

// File: rtl/conv2d_seq_ctrl.sv
// Time-multiplexed 2-D convolution sequencer. Walks co, orow, ocol (outer) and
// ci, kr, kc (inner), issues one input/weight read per cycle, accumulates the
// signed products on a single MAC and writes saturated results row-major.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a layer (accepted only when idle)
//   busy       : layer in progress
//   done       : one-cycle pulse after the last result is accepted
//   bus        : RAM read ports and result write port (master side)
module conv2d_seq_ctrl #(
    parameter int unsigned in_channels  = 1,
    parameter int unsigned out_channels = 1,
    parameter int unsigned kernel_rows  = 3,
    parameter int unsigned kernel_cols  = 3,
    parameter int unsigned stride_row   = 1,
    parameter int unsigned stride_col   = 1,
    parameter int unsigned rows         = 28,
    parameter int unsigned cols         = 28,
    parameter int unsigned data_size    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    conv2d_seq_ctrl_if.master bus
);
    function automatic int unsigned cw(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam bit params_ok = (in_channels >= 1) && (out_channels >= 1) &&
                               (kernel_rows >= 1) && (kernel_cols >= 1) &&
                               (stride_row >= 1) && (stride_col >= 1) &&
                               (rows >= kernel_rows) && (cols >= kernel_cols) &&
                               (data_size >= 2);

    localparam int unsigned out_rows = params_ok ? (rows - kernel_rows) / stride_row + 1 : 1;
    localparam int unsigned out_cols = params_ok ? (cols - kernel_cols) / stride_col + 1 : 1;
    localparam int unsigned terms    = in_channels * kernel_rows * kernel_cols;
    localparam int unsigned in_aw    = cw(in_channels * rows * cols);
    localparam int unsigned w_aw     = cw(out_channels * terms);
    localparam int unsigned b_aw     = cw(out_channels);
    localparam int unsigned o_aw     = cw(out_channels * out_rows * out_cols);
    localparam int unsigned acc_w    = 2 * data_size + $clog2(terms) + 1;
    localparam int unsigned prod_w   = 2 * data_size;
    localparam int unsigned co_w     = cw(out_channels);
    localparam int unsigned or_w     = cw(out_rows);
    localparam int unsigned oc_w     = cw(out_cols);
    localparam int unsigned ci_w     = cw(in_channels);
    localparam int unsigned kr_w     = cw(kernel_rows);
    localparam int unsigned kc_w     = cw(kernel_cols);

    localparam logic [co_w-1:0] co_max = co_w'(out_channels - 1);
    localparam logic [or_w-1:0] or_max = or_w'(out_rows - 1);
    localparam logic [oc_w-1:0] oc_max = oc_w'(out_cols - 1);
    localparam logic [ci_w-1:0] ci_max = ci_w'(in_channels - 1);
    localparam logic [kr_w-1:0] kr_max = kr_w'(kernel_rows - 1);
    localparam logic [kc_w-1:0] kc_max = kc_w'(kernel_cols - 1);

    localparam logic signed [acc_w-1:0] out_max = acc_w'((longint'(1) <<< (data_size - 1)) - longint'(1));
    localparam logic signed [acc_w-1:0] out_min = acc_w'(-(longint'(1) <<< (data_size - 1)));

    if (!params_ok) begin : g_param_check
        $error("conv2d_seq_ctrl: kernel larger than input, or zero-sized stride/dimension");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [co_w-1:0] co_q, co_d;
    logic [or_w-1:0] orow_q, orow_d;
    logic [oc_w-1:0] ocol_q, ocol_d;
    logic [ci_w-1:0] ci_q, ci_d;
    logic [kr_w-1:0] kr_q, kr_d;
    logic [kc_w-1:0] kc_q, kc_d;

    // last_term: final term of the pixel already issued; *_vld: RAM data valid this cycle
    logic last_term_q, last_term_d;
    logic bias_vld_q, bias_vld_d;
    logic mac_vld_q, mac_vld_d;

    logic signed [acc_w-1:0] acc_q, acc_d;

    logic [in_aw-1:0]     in_addr_q, in_addr_d;
    logic [w_aw-1:0]      w_addr_q, w_addr_d;
    logic [b_aw-1:0]      b_addr_q, b_addr_d;
    logic                 out_valid_q, out_valid_d;
    logic [o_aw-1:0]      out_addr_q, out_addr_d;
    logic [data_size-1:0] out_data_q, out_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                     issue;
    logic                     term_last;
    logic                     pix_last;
    logic signed [prod_w-1:0] prod;
    logic signed [acc_w-1:0]  acc_sum;

    // MAC datapath: product of the returned sample/weight pair, added into the running sum.
    assign prod      = $signed(bus.in_data) * $signed(bus.w_data);
    assign acc_sum   = acc_q + acc_w'(prod);
    assign term_last = (ci_q == ci_max) && (kr_q == kr_max) && (kc_q == kc_max);
    assign pix_last  = (co_q == co_max) && (orow_q == or_max) && (ocol_q == oc_max);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            co_q        <= '0;
            orow_q      <= '0;
            ocol_q      <= '0;
            ci_q        <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            last_term_q <= 1'b0;
            bias_vld_q  <= 1'b0;
            mac_vld_q   <= 1'b0;
            acc_q       <= '0;
            in_addr_q   <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            co_q        <= co_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            ci_q        <= ci_d;
            kr_q        <= kr_d;
            kc_q        <= kc_d;
            last_term_q <= last_term_d;
            bias_vld_q  <= bias_vld_d;
            mac_vld_q   <= mac_vld_d;
            acc_q       <= acc_d;
            in_addr_q   <= in_addr_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d     = state_q;
        co_d        = co_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        ci_d        = ci_q;
        kr_d        = kr_q;
        kc_d        = kc_q;
        last_term_d = last_term_q;
        bias_vld_d  = 1'b0;
        mac_vld_d   = 1'b0;
        acc_d       = acc_q;
        in_addr_d   = in_addr_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        issue       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_BIAS;
                    busy_d   = 1'b1;
                    b_addr_d = b_aw'(co_q);
                end
            end
            S_BIAS: begin
                state_d    = S_MAC;
                bias_vld_d = 1'b1;
                issue      = 1'b1;
            end
            S_MAC: begin
                mac_vld_d = 1'b1;
                if (last_term_q) begin
                    state_d     = S_DRAIN;
                    last_term_d = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            S_DRAIN: begin
                // acc_sum already includes the final product returned this cycle
                state_d     = S_WRITE;
                out_valid_d = 1'b1;
                out_addr_d  = o_aw'(32'(co_q) * 32'(out_rows * out_cols)
                                  + 32'(orow_q) * 32'(out_cols) + 32'(ocol_q));
                if (acc_sum > out_max) begin
                    out_data_d = data_size'(out_max);
                end else if (acc_sum < out_min) begin
                    out_data_d = data_size'(out_min);
                end else begin
                    out_data_d = data_size'(acc_sum);
                end
            end
            S_WRITE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (ocol_q == oc_max) begin
                        ocol_d = '0;
                        if (orow_q == or_max) begin
                            orow_d = '0;
                            co_d   = (co_q == co_max) ? '0 : co_q + co_w'(1);
                        end else begin
                            orow_d = orow_q + or_w'(1);
                        end
                    end else begin
                        ocol_d = ocol_q + oc_w'(1);
                    end
                    if (pix_last) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_BIAS;
                        b_addr_d = b_aw'(co_d);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bias_vld_q) begin
            acc_d = acc_w'($signed(bus.b_data));
        end else if (mac_vld_q) begin
            acc_d = acc_sum;
        end

        // Present the current term's addresses, then step kc -> kr -> ci.
        if (issue) begin
            in_addr_d   = in_aw'(32'(ci_q) * 32'(rows * cols)
                               + (32'(orow_q) * 32'(stride_row) + 32'(kr_q)) * 32'(cols)
                               + 32'(ocol_q) * 32'(stride_col) + 32'(kc_q));
            w_addr_d    = w_aw'(((32'(co_q) * 32'(in_channels) + 32'(ci_q)) * 32'(kernel_rows)
                                 + 32'(kr_q)) * 32'(kernel_cols) + 32'(kc_q));
            last_term_d = term_last;
            if (kc_q == kc_max) begin
                kc_d = '0;
                if (kr_q == kr_max) begin
                    kr_d = '0;
                    ci_d = (ci_q == ci_max) ? '0 : ci_q + ci_w'(1);
                end else begin
                    kr_d = kr_q + kr_w'(1);
                end
            end else begin
                kc_d = kc_q + kc_w'(1);
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.in_addr   = in_addr_q;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_data  = out_data_q;
endmodule
